// File: rtl/pixel_packer.sv
// Pixel packer: groups 10-bit camera pixels four at a time into 40-bit
// words, tags first/last word of a frame and buffers them in a FWFT FIFO.
//
// Ports:
//   pclk          clock, rising edge
//   reset         synchronous, active-high
//   pixel_in      10-bit pixel sample
//   pixel_valid   pixel_in valid this cycle (no backpressure upstream)
//   sof           single-cycle start-of-frame pulse
//   out_data      four packed pixels, first pixel in [9:0]
//   out_valid     out_data/out_sop/out_eop valid
//   out_ready     downstream accepts the head word
//   out_sop       first word of a frame
//   out_eop       last word of a frame
//   frame_count   complete frames enqueued, wraps at 16 bits
//   overflow      sticky, a word was dropped on a full FIFO
//   frame_error   one-cycle pulse on a short or dropped frame

module pixel_packer #(
    parameter int FRAME_WIDTH = 2300,
    parameter int FRAME_LINES = 1540,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [9:0]  pixel_in,
    input  logic        pixel_valid,
    input  logic        sof,
    output logic [39:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [15:0] frame_count,
    output logic        overflow,
    output logic        frame_error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [23:0] LAST_PIX = 24'(FRAME_WIDTH * FRAME_LINES - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_WAIT_SOF,
        ST_ACTIVE,
        ST_DONE,
        ST_DROP
    } state_t;

    // Packing state
    state_t      state_q;
    logic [1:0]  lane_q;
    logic [23:0] pix_cnt_q;
    logic [9:0]  lane0_q;
    logic [9:0]  lane1_q;
    logic [9:0]  lane2_q;
    logic        sop_pend_q;

    // Completed word waiting to be pushed on the next edge
    logic        word_vld_q;
    logic        word_sop_q;
    logic        word_eop_q;
    logic [39:0] word_q;

    logic [15:0] frame_count_q;
    logic        overflow_q;
    logic        frame_error_q;

    // FIFO storage: {sop, eop, data}
    logic [41:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic [41:0]   head;

    logic full;
    logic push;
    logic drop;
    logic pop;
    logic last_pix;

    // A push that meets a full FIFO is dropped even if a pop happens
    // on the same edge.
    assign full     = (cnt_q == FULL_CNT);
    assign push     = word_vld_q && !full;
    assign drop     = word_vld_q && full;
    assign pop      = out_valid && out_ready;
    assign last_pix = (pix_cnt_q == LAST_PIX);

    // Frame FSM and lane packer
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q       <= ST_WAIT_SOF;
            lane_q        <= 2'd0;
            pix_cnt_q     <= 24'd0;
            lane0_q       <= 10'd0;
            lane1_q       <= 10'd0;
            lane2_q       <= 10'd0;
            sop_pend_q    <= 1'b0;
            word_vld_q    <= 1'b0;
            word_sop_q    <= 1'b0;
            word_eop_q    <= 1'b0;
            word_q        <= 40'd0;
            frame_count_q <= 16'd0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            word_vld_q    <= 1'b0;
            frame_error_q <= 1'b0;

            if (drop) begin
                overflow_q    <= 1'b1;
                frame_error_q <= 1'b1;
            end

            if (push && word_eop_q) begin
                frame_count_q <= frame_count_q + 16'd1;
            end

            if (sof) begin
                // sof wins over everything; a coincident pixel
                // becomes pixel 1 of the new frame.
                if (state_q == ST_ACTIVE) begin
                    frame_error_q <= 1'b1;
                end
                state_q    <= ST_ACTIVE;
                sop_pend_q <= 1'b1;
                lane0_q    <= pixel_in;
                lane_q     <= pixel_valid ? 2'd1 : 2'd0;
                pix_cnt_q  <= pixel_valid ? 24'd1 : 24'd0;
            end else if (drop) begin
                state_q <= ST_DROP;
            end else begin
                case (state_q)
                    ST_ACTIVE: begin
                        if (pixel_valid) begin
                            pix_cnt_q <= pix_cnt_q + 24'd1;
                            lane_q    <= lane_q + 2'd1;
                            case (lane_q)
                                2'd0: lane0_q <= pixel_in;
                                2'd1: lane1_q <= pixel_in;
                                2'd2: lane2_q <= pixel_in;
                                default: begin
                                    word_q <= {pixel_in, lane2_q,
                                               lane1_q, lane0_q};
                                    word_vld_q <= 1'b1;
                                    word_sop_q <= sop_pend_q;
                                    word_eop_q <= last_pix;
                                    sop_pend_q <= 1'b0;
                                    if (last_pix) begin
                                        state_q <= ST_DONE;
                                    end
                                end
                            endcase
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    // FIFO occupancy
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {word_sop_q, word_eop_q, word_q};
        end
    end

    // First-word-fall-through head; zeroed while empty so stale RAM
    // contents never reach the outputs.
    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (cnt_q != '0);
    assign out_sop   = out_valid ? head[41] : 1'b0;
    assign out_eop   = out_valid ? head[40] : 1'b0;
    assign out_data  = out_valid ? head[39:0] : 40'd0;

    assign frame_count = frame_count_q;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Bench for pixel_packer: directed frame scenarios plus random frames,
// checked against a frame-level reference model and word scoreboard.

module tb_pixel_packer;

    localparam int FW    = 8;
    localparam int FL    = 2;
    localparam int DEPTH = 4;
    localparam int TOTAL = FW * FL;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [39:0] data;
    } word_t;

    logic        pclk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_in;
    logic        pixel_valid;
    logic        sof;
    logic [39:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] frame_count;
    logic        overflow;
    logic        frame_error;

    pixel_packer #(
        .FRAME_WIDTH (FW),
        .FRAME_LINES (FL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .sof         (sof),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .frame_count (frame_count),
        .overflow    (overflow),
        .frame_error (frame_error)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: frame-level rules on pixel events
    word_t      exp_q[$];
    logic [9:0] part[$];
    bit         m_active;
    bit         m_first;
    int         m_n;
    int         exp_frames;
    int         exp_err;
    int         err_seen;
    bit         exp_ovf;
    int         rdy_mode;
    bit         tog;

    function automatic void model_reset();
        exp_q.delete();
        part.delete();
        m_active   = 0;
        m_first    = 0;
        m_n        = 0;
        exp_frames = 0;
        exp_ovf    = 0;
    endfunction

    function automatic void model_step(bit s, bit v, logic [9:0] p);
        word_t w;
        if (s) begin
            if (m_active) exp_err++;
            m_active = 1;
            m_first  = 1;
            m_n      = 0;
            part.delete();
        end
        if (v && m_active) begin
            part.push_back(p);
            m_n++;
            if (part.size() == 4) begin
                w.data = {part[3], part[2], part[1], part[0]};
                w.sop  = m_first;
                w.eop  = (m_n == TOTAL);
                part.delete();
                // While stalled nothing drains, so the queue length
                // is the buffer occupancy.
                if (rdy_mode == 1 && exp_q.size() == DEPTH) begin
                    exp_ovf  = 1;
                    exp_err++;
                    m_active = 0;
                end else begin
                    m_first = 0;
                    exp_q.push_back(w);
                    if (w.eop) begin
                        exp_frames++;
                        m_active = 0;
                    end
                end
            end
        end
    endfunction

    task automatic cyc(input bit s, input bit v, input logic [9:0] p);
        model_step(s, v, p);
        sof         = s;
        pixel_valid = v;
        pixel_in    = p;
        tog         = ~tog;
        if (rdy_mode == 0)
            out_ready = 1'b1;
        else if (rdy_mode == 1)
            out_ready = 1'b0;
        else
            out_ready = tog | 1'($urandom_range(0, 1));
        @(posedge pclk);
        #1;
        sof         = 1'b0;
        pixel_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 10'($urandom));
    endtask

    task automatic send_frame(input int base);
        cyc(1, 0, 10'd0);
        for (int i = 0; i < TOTAL; i++) cyc(0, 1, 10'(base + i));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            cyc(0, 0, 10'd0);
        idle(3);
        chk({tag, "_drain_left"}, exp_q.size(), 0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_frame_count"}, frame_count, exp_frames & 'hFFFF);
        chk({tag, "_overflow"}, overflow, exp_ovf);
        chk({tag, "_frame_errors"}, err_seen, exp_err);
    endtask

    // Scoreboard and hold-stability monitor
    word_t      mw;
    bit         hold;
    logic [41:0] held;

    always @(negedge pclk) begin
        if (reset) begin
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_word", {out_sop, out_eop, out_data}, held);
            end
            if (frame_error) err_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", out_valid, 0);
                end else begin
                    mw = exp_q.pop_front();
                    chk("word_data", out_data, mw.data);
                    chk("word_sop", out_sop, mw.sop);
                    chk("word_eop", out_eop, mw.eop);
                end
                hold = 0;
            end else begin
                hold = out_valid;
                held = {out_sop, out_eop, out_data};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        int npx;
        reset       = 1'b1;
        sof         = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = 10'd0;
        out_ready   = 1'b0;
        rdy_mode    = 0;
        tog         = 0;
        exp_err     = 0;
        err_seen    = 0;
        hold        = 0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sop", out_sop, 0);
        chk("rst_out_eop", out_eop, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_error", frame_error, 0);
        reset = 1'b0;

        // Pixels before first sof, then a frame with latency check
        for (int i = 0; i < 5; i++) cyc(0, 1, 10'($urandom));
        cyc(1, 0, 10'd0);
        for (int i = 1; i <= 3; i++) cyc(0, 1, 10'(i));
        cyc(0, 1, 10'd4);
        chk("lat_early", out_valid, 0);
        cyc(0, 0, 10'd0);
        chk("lat_exact", out_valid, 1);
        chk("first_word", out_data, {10'd4, 10'd3, 10'd2, 10'd1});
        chk("first_sop", out_sop, 1);
        for (int i = 5; i <= TOTAL; i++) cyc(0, 1, 10'(i));
        drain("basic");
        check_status("basic");

        // Short frame followed by a full frame
        cyc(1, 0, 10'd0);
        for (int i = 1; i <= 10; i++) cyc(0, 1, 10'(100 + i));
        send_frame(200);
        drain("short");
        check_status("short");

        // sof coincident with a pixel
        cyc(1, 1, 10'h3FF);
        for (int i = 1; i < TOTAL; i++) cyc(0, 1, 10'(300 + i));
        drain("coinc");
        check_status("coinc");

        // Stalled output across three frames
        rdy_mode = 1;
        send_frame(400);
        send_frame(500);
        send_frame(600);
        idle(4);
        chk("ovf_head_valid", out_valid, 1);
        check_status("ovf");
        rdy_mode = 0;
        drain("ovf_release");
        send_frame(700);
        drain("ovf_after");
        check_status("ovf_after");

        // Reset mid-frame
        cyc(1, 0, 10'd0);
        for (int i = 1; i <= 6; i++) cyc(0, 1, 10'(800 + i));
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        reset = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_frame_count", frame_count, 0);
        chk("midrst_overflow", overflow, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 10'($urandom));
        idle(4);
        chk("midrst_ignored", out_valid, 0);
        send_frame(900);
        drain("midrst");
        check_status("midrst");

        // Random frames, gaps and backpressure
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0)
                npx = $urandom_range(0, TOTAL - 1);
            else if (kind == 3)
                npx = TOTAL + $urandom_range(1, 6);
            else
                npx = TOTAL;
            if (npx > 0 && $urandom_range(0, 1) == 1) begin
                cyc(1, 1, 10'($urandom));
                npx--;
            end else begin
                cyc(1, 0, 10'd0);
            end
            for (int i = 0; i < npx; i++) begin
                if ($urandom_range(0, 2) == 0) cyc(0, 0, 10'($urandom));
                cyc(0, 1, 10'($urandom));
            end
            for (int i = $urandom_range(0, 3); i > 0; i--)
                cyc(0, 1'($urandom_range(0, 1)), 10'($urandom));
        end
        send_frame(int'($urandom_range(0, 1000)));
        rdy_mode = 0;
        drain("rand");
        check_status("rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
